// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: sequencing controller between the keypad front end and a
// shared multi-cycle signed ALU. It builds signed decimal operands A and B from
// key codes, latches the operator, issues one ALU operation on '=' and presents
// the result (or an error) to the display driver.
//
// Ports:
//   clk, nRST           clock, asynchronous active-low reset
//   key_valid/key_code  key from the keypad, held until key_read
//   key_read            one-cycle acknowledge of an accepted key
//   alu_start/alu_op    one-cycle ALU launch and operation (00 add, 01 sub, 10 mul)
//   alu_a/alu_b         signed operands, stable from launch until alu_done
//   alu_done/alu_result/alu_ovf  ALU completion, result and overflow
//   display_output      value for the display driver
//   complete/error      result shown / overflow occurred
//
// Optional feature macro: OPSEQ_CHAIN_EN. When defined, an operator pressed
// while a result is shown continues the calculation with that result as A.
module calc_op_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned MAX_MAG = 32767
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_read,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  output logic [WIDTH-1:0] display_output,
  output logic             complete,
  output logic             error
);

  localparam int unsigned CalcW = WIDTH + 4;

  localparam logic [3:0] KeyAdd = 4'd3;
  localparam logic [3:0] KeySub = 4'd7;
  localparam logic [3:0] KeyMul = 4'd11;
  localparam logic [3:0] KeyEq  = 4'd12;
  localparam logic [3:0] KeyClr = 4'd14;
  localparam logic [3:0] KeyNeg = 4'd15;

  typedef enum logic [2:0] {
    StEnterA, StEnterB, StIssue, StWaitAlu, StShow, StError
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d, result_q, result_d;
  logic             a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_dig_q, b_dig_d;
  logic [1:0]       op_q, op_d;
  logic             key_read_q, key_read_d, guard_q, guard_d;
  logic             complete_q, complete_d, error_q, error_d;

  // Key decode
  logic             key_is_digit, key_is_op;
  logic [3:0]       key_digit;
  logic [1:0]       key_op;

  always_comb begin
    key_is_digit = 1'b1;
    key_digit    = 4'd0;
    case (key_code)
      4'd0, 4'd1, 4'd2:  key_digit = key_code + 4'd1;
      4'd4, 4'd5, 4'd6:  key_digit = key_code;
      4'd8, 4'd9, 4'd10: key_digit = key_code - 4'd1;
      4'd13:             key_digit = 4'd0;
      default:           key_is_digit = 1'b0;
    endcase
  end

  assign key_is_op = (key_code == KeyAdd) || (key_code == KeySub) || (key_code == KeyMul);

  always_comb begin
    case (key_code)
      KeyAdd:  key_op = 2'b00;
      KeySub:  key_op = 2'b01;
      default: key_op = 2'b10;
    endcase
  end

  // Digit append is evaluated wide so an out-of-range entry is detected, not wrapped.
  logic [WIDTH-1:0] cur_mag, new_mag;
  logic [CalcW-1:0] mag_ext;
  logic             digit_ok;

  assign cur_mag  = (state_q == StEnterB) ? b_mag_q : a_mag_q;
  assign mag_ext  = {4'b0000, cur_mag} * CalcW'(10) + CalcW'(key_digit);
  assign digit_ok = (mag_ext <= CalcW'(MAX_MAG));
  assign new_mag  = mag_ext[WIDTH-1:0];

  logic [WIDTH-1:0] a_val, b_val;
  assign a_val = a_neg_q ? -a_mag_q : a_mag_q;
  assign b_val = b_neg_q ? -b_mag_q : b_mag_q;

`ifdef OPSEQ_CHAIN_EN
  logic [WIDTH-1:0] res_abs;
  assign res_abs = result_q[WIDTH-1] ? -result_q : result_q;
`endif

  // The acknowledge cycle and the one after it are blind, so a key still held
  // while the producer reacts to key_read is not taken twice.
  logic accept;
  assign accept = key_valid && !key_read_q && !guard_q &&
                  ((state_q == StEnterA) || (state_q == StEnterB) ||
                   (state_q == StShow)   || (state_q == StError));

  logic do_clear, load_digit, load_neg;

  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    a_neg_d    = a_neg_q;
    b_mag_d    = b_mag_q;
    b_neg_d    = b_neg_q;
    b_dig_d    = b_dig_q;
    op_d       = op_q;
    result_d   = result_q;
    key_read_d = accept;
    guard_d    = key_read_q;
    do_clear   = 1'b0;
    load_digit = 1'b0;
    load_neg   = 1'b0;

    unique case (state_q)
      StEnterA: begin
        if (accept) begin
          if (key_is_digit) begin
            if (digit_ok) a_mag_d = new_mag;
          end else if (key_code == KeyNeg) begin
            a_neg_d = ~a_neg_q;
          end else if (key_is_op) begin
            op_d    = key_op;
            state_d = StEnterB;
          end else if (key_code == KeyClr) begin
            do_clear = 1'b1;
          end
        end
      end
      StEnterB: begin
        if (accept) begin
          if (key_is_digit) begin
            if (digit_ok) begin
              b_mag_d = new_mag;
              b_dig_d = 1'b1;
            end
          end else if (key_code == KeyNeg) begin
            b_neg_d = ~b_neg_q;
          end else if (key_is_op) begin
            // Operator can still be changed until B has been started
            if (!b_dig_q && !b_neg_q) op_d = key_op;
          end else if (key_code == KeyEq) begin
            state_d = StIssue;
          end else if (key_code == KeyClr) begin
            do_clear = 1'b1;
          end
        end
      end
      StIssue: state_d = StWaitAlu;
      StWaitAlu: begin
        if (alu_done) begin
          if (alu_ovf) begin
            state_d = StError;
          end else begin
            result_d = alu_result;
            state_d  = StShow;
          end
        end
      end
      StShow: begin
        if (accept) begin
          if (key_is_digit) begin
            do_clear   = 1'b1;
            load_digit = 1'b1;
          end else if (key_code == KeyNeg) begin
            do_clear = 1'b1;
            load_neg = 1'b1;
          end else if (key_code == KeyClr) begin
            do_clear = 1'b1;
`ifdef OPSEQ_CHAIN_EN
          end else if (key_is_op) begin
            a_neg_d = result_q[WIDTH-1];
            a_mag_d = res_abs;
            b_mag_d = '0;
            b_neg_d = 1'b0;
            b_dig_d = 1'b0;
            op_d    = key_op;
            state_d = StEnterB;
`endif
          end
        end
      end
      StError: begin
        if (accept && (key_code == KeyClr)) do_clear = 1'b1;
      end
      default: state_d = StEnterA;
    endcase

    if (do_clear) begin
      a_mag_d  = '0;
      a_neg_d  = 1'b0;
      b_mag_d  = '0;
      b_neg_d  = 1'b0;
      b_dig_d  = 1'b0;
      op_d     = 2'b00;
      result_d = '0;
      state_d  = StEnterA;
    end
    if (load_digit) a_mag_d = WIDTH'(key_digit);
    if (load_neg)   a_neg_d = 1'b1;

    complete_d = (state_d == StShow);
    error_d    = (state_d == StError);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StEnterA;
      a_mag_q    <= '0;
      a_neg_q    <= 1'b0;
      b_mag_q    <= '0;
      b_neg_q    <= 1'b0;
      b_dig_q    <= 1'b0;
      op_q       <= 2'b00;
      result_q   <= '0;
      key_read_q <= 1'b0;
      guard_q    <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      a_neg_q    <= a_neg_d;
      b_mag_q    <= b_mag_d;
      b_neg_q    <= b_neg_d;
      b_dig_q    <= b_dig_d;
      op_q       <= op_d;
      result_q   <= result_d;
      key_read_q <= key_read_d;
      guard_q    <= guard_d;
      complete_q <= complete_d;
      error_q    <= error_d;
    end
  end

  // While the ALU runs the display keeps the ENTER_B view, which is still valid.
  always_comb begin
    display_output = '0;
    unique case (state_q)
      StEnterA:                    display_output = a_val;
      StEnterB, StIssue, StWaitAlu: display_output = b_dig_q ? b_val : a_val;
      StShow:                      display_output = result_q;
      default:                     display_output = '0;
    endcase
  end

  assign key_read  = key_read_q;
  assign alu_start = (state_q == StIssue);
  assign alu_op    = op_q;
  assign alu_a     = a_val;
  assign alu_b     = b_val;
  assign complete  = complete_q;
  assign error     = error_q;

endmodule
